// File: rtl/decstage.sv
// decstage: instruction-decode stage. Holds the instruction register,
// splits it into register/immediate fields, owns the 32x32 register file
// with write-through bypass, and produces the extended immediate.
module decstage #(
  parameter logic [31:0] IR_RESET = 32'h00000000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] Instr,
  input  logic        IR_LdEn,
  input  logic        RF_WrEn,
  input  logic        RF_WrData_sel,
  input  logic [31:0] ALU_out,
  input  logic [31:0] MEM_out,
  input  logic        RF_B_sel,
  input  logic [1:0]  ImmExt,
  output logic [31:0] IR,
  output logic [31:0] Immed,
  output logic [31:0] RF_A,
  output logic [31:0] RF_B
);

  // Immediate-extension modes; the reserved encoding falls back to sign-extend.
  localparam logic [1:0] IMM_ZERO  = 2'b00;
  localparam logic [1:0] IMM_SIGN  = 2'b01;
  localparam logic [1:0] IMM_UPPER = 2'b10;

  logic [31:0] ir_q;
  logic [31:0] regs [0:31];

  logic [4:0]  rs;
  logic [4:0]  rd;
  logic [4:0]  rt;
  logic [15:0] imm;

  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr_live;
  logic [4:0]  addr_b;

  assign IR = ir_q;

  // Field extraction. Note that in this datapath rd sits at [20:16] and
  // rt at [15:11]; rt overlaps the upper bits of the immediate.
  assign rs  = ir_q[25:21];
  assign rd  = ir_q[20:16];
  assign rt  = ir_q[15:11];
  assign imm = ir_q[15:0];

  // Writes always target rd of the instruction currently held in IR, so a
  // simultaneous IR load still writes using the old instruction's rd.
  assign wr_addr = rd;
  assign wr_data = RF_WrData_sel ? MEM_out : ALU_out;
  assign wr_live = RF_WrEn && (wr_addr != 5'd0);
  assign addr_b  = RF_B_sel ? rd : rt;

  // Instruction register: reset wins over load, otherwise hold.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      ir_q <= IR_RESET;
    end else if (IR_LdEn) begin
      ir_q <= Instr;
    end
  end

  // Register file storage: reset clears every entry and drops any write in
  // the same cycle; writes to r0 are discarded so it stays zero.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= 32'h00000000;
      end
    end else if (wr_live) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Read port A: r0 reads zero, a matching in-flight write is forwarded.
  always_comb begin
    RF_A = 32'h00000000;
    if (rs == 5'd0) begin
      RF_A = 32'h00000000;
    end else if (wr_live && (wr_addr == rs)) begin
      RF_A = wr_data;
    end else begin
      RF_A = regs[rs];
    end
  end

  // Read port B: same rules as port A, using the selected rt/rd address.
  always_comb begin
    RF_B = 32'h00000000;
    if (addr_b == 5'd0) begin
      RF_B = 32'h00000000;
    end else if (wr_live && (wr_addr == addr_b)) begin
      RF_B = wr_data;
    end else begin
      RF_B = regs[addr_b];
    end
  end

  // Immediate extender; branch offsets are shifted later in the fetch stage.
  always_comb begin
    Immed = {{16{imm[15]}}, imm};
    case (ImmExt)
      IMM_ZERO:  Immed = {16'h0000, imm};
      IMM_SIGN:  Immed = {{16{imm[15]}}, imm};
      IMM_UPPER: Immed = {imm, 16'h0000};
      default:   Immed = {{16{imm[15]}}, imm};
    endcase
  end

endmodule

// File: tb/tb_decstage.sv
// tb_decstage: directed stimulus for decstage with a queue-based scoreboard.
// Stimulus pushes expected output values for the current cycle; a monitor
// on the falling edge pops and compares them against the DUT outputs.
module tb_decstage;

  localparam int SEL_IR    = 0;
  localparam int SEL_IMMED = 1;
  localparam int SEL_RFA   = 2;
  localparam int SEL_RFB   = 3;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] val;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [31:0] instr;
  logic        ir_ld_en;
  logic        rf_wr_en;
  logic        rf_wr_data_sel;
  logic [31:0] alu_out;
  logic [31:0] mem_out;
  logic        rf_b_sel;
  logic [1:0]  imm_ext;
  logic [31:0] ir;
  logic [31:0] immed;
  logic [31:0] rf_a;
  logic [31:0] rf_b;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  decstage #(.IR_RESET(32'h00000000)) dut (
    .Clk          (clk),
    .Reset        (reset),
    .Instr        (instr),
    .IR_LdEn      (ir_ld_en),
    .RF_WrEn      (rf_wr_en),
    .RF_WrData_sel(rf_wr_data_sel),
    .ALU_out      (alu_out),
    .MEM_out      (mem_out),
    .RF_B_sel     (rf_b_sel),
    .ImmExt       (imm_ext),
    .IR           (ir),
    .Immed        (immed),
    .RF_A         (rf_a),
    .RF_B         (rf_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                     input logic [4:0] rd, input logic [15:0] low);
    return {op, rs, rd, low};
  endfunction

  // Waits for the next rising edge, then drives every input for this cycle.
  task automatic applyStimulus(input logic rst, input logic ld, input logic [31:0] ins,
                               input logic wr, input logic wsel, input logic [31:0] alu,
                               input logic [31:0] mem, input logic bsel,
                               input logic [1:0] ie);
    @(posedge clk);
    #1;
    reset          = rst;
    ir_ld_en       = ld;
    instr          = ins;
    rf_wr_en       = wr;
    rf_wr_data_sel = wsel;
    alu_out        = alu;
    mem_out        = mem;
    rf_b_sel       = bsel;
    imm_ext        = ie;
  endtask

  // Queues an expected value for the current cycle's outputs.
  task automatic expectOutput(input string name, input int sel, input logic [31:0] val);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    logic [31:0] act;
    case (e.sel)
      SEL_IR:    act = ir;
      SEL_IMMED: act = immed;
      SEL_RFA:   act = rf_a;
      default:   act = rf_b;
    endcase
    checks++;
    if (act !== e.val) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", e.name, act, e.val);
    end
  endtask

  // Monitor: consume everything queued for this cycle on the falling edge.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      checkOutput(exp_q.pop_front());
    end
  end

  initial begin
    reset = 1'b1; ir_ld_en = 1'b0; instr = 32'h0; rf_wr_en = 1'b0;
    rf_wr_data_sel = 1'b0; alu_out = 32'h0; mem_out = 32'h0; rf_b_sel = 1'b0;
    imm_ext = 2'b00;

    // Reset with load and write requested; both must be lost.
    applyStimulus(1, 1, 32'hFFFFFFFF, 1, 0, 32'h00001234, 32'h0, 0, 2'b00);
    applyStimulus(0, 0, 32'hFFFFFFFF, 0, 0, 32'h0, 32'h0, 0, 2'b00);
    expectOutput("reset_ir", SEL_IR, 32'h0);
    expectOutput("reset_rfa", SEL_RFA, 32'h0);
    expectOutput("reset_rfb", SEL_RFB, 32'h0);
    expectOutput("reset_immed", SEL_IMMED, 32'h0);

    // Sweep all 32 registers through both ports.
    for (int i = 0; i < 32; i++) begin
      applyStimulus(0, 1, mk(6'd0, 5'(i), 5'(i), {5'(i), 11'd0}), 0, 0, 32'h0, 32'h0, i[0], 2'b00);
      applyStimulus(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, i[0], 2'b00);
      expectOutput($sformatf("sweep_a_r%0d", i), SEL_RFA, 32'h0);
      expectOutput($sformatf("sweep_b_r%0d", i), SEL_RFB, 32'h0);
    end

    // ALU write into r5, then read back through port A.
    applyStimulus(0, 1, mk(6'd0, 5'd0, 5'd5, 16'h0), 0, 0, 32'h0, 32'h0, 0, 2'b00);
    applyStimulus(0, 0, 32'h0, 1, 0, 32'hDEADBEEF, 32'h0, 0, 2'b00);
    expectOutput("ir_rd5", SEL_IR, mk(6'd0, 5'd0, 5'd5, 16'h0));
    expectOutput("wr5_rfa_rs0", SEL_RFA, 32'h0);
    applyStimulus(0, 1, mk(6'd0, 5'd5, 5'd0, 16'h0), 0, 0, 32'h0, 32'h0, 0, 2'b00);
    applyStimulus(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 2'b00);
    expectOutput("read_r5", SEL_RFA, 32'hDEADBEEF);

    // MEM write into r9, checked via bypass and then from storage on port B.
    applyStimulus(0, 1, mk(6'd0, 5'd0, 5'd9, 16'h0), 0, 0, 32'h0, 32'h0, 1, 2'b00);
    applyStimulus(0, 0, 32'h0, 1, 1, 32'h0BADF00D, 32'h12345678, 1, 2'b00);
    expectOutput("bypass_b_r9", SEL_RFB, 32'h12345678);
    applyStimulus(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 1, 2'b00);
    expectOutput("read_r9", SEL_RFB, 32'h12345678);

    // r0 writes are discarded and never bypassed.
    applyStimulus(0, 1, mk(6'd0, 5'd0, 5'd0, 16'h0), 0, 0, 32'h0, 32'h0, 1, 2'b00);
    applyStimulus(0, 0, 32'h0, 1, 0, 32'hFFFFFFFF, 32'h0, 1, 2'b00);
    expectOutput("r0_nobypass_a", SEL_RFA, 32'h0);
    expectOutput("r0_nobypass_b", SEL_RFB, 32'h0);
    applyStimulus(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 1, 2'b00);
    expectOutput("r0_after_write", SEL_RFA, 32'h0);

    // Bypass with rs == rd == 7, then the stored value after the edge.
    applyStimulus(0, 1, mk(6'd0, 5'd7, 5'd7, 16'h0), 0, 0, 32'h0, 32'h0, 0, 2'b00);
    applyStimulus(0, 0, 32'h0, 1, 0, 32'hA5A5A5A5, 32'h0, 0, 2'b00);
    expectOutput("bypass_a_r7", SEL_RFA, 32'hA5A5A5A5);
    applyStimulus(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 2'b00);
    expectOutput("stored_a_r7", SEL_RFA, 32'hA5A5A5A5);

    // Immediate modes with imm = 8001.
    applyStimulus(0, 1, mk(6'd0, 5'd0, 5'd0, 16'h8001), 0, 0, 32'h0, 32'h0, 0, 2'b00);
    applyStimulus(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 2'b00);
    expectOutput("imm_zero", SEL_IMMED, 32'h00008001);
    applyStimulus(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 2'b01);
    expectOutput("imm_sign", SEL_IMMED, 32'hFFFF8001);
    applyStimulus(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 2'b10);
    expectOutput("imm_upper", SEL_IMMED, 32'h80010000);
    applyStimulus(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 2'b11);
    expectOutput("imm_reserved", SEL_IMMED, 32'hFFFF8001);

    // IR holds while Instr changes without a load.
    applyStimulus(0, 0, 32'hFFFFFFFF, 0, 0, 32'h0, 32'h0, 0, 2'b00);
    expectOutput("ir_hold_1", SEL_IR, mk(6'd0, 5'd0, 5'd0, 16'h8001));
    applyStimulus(0, 0, 32'h13572468, 0, 0, 32'h0, 32'h0, 0, 2'b00);
    expectOutput("ir_hold_2", SEL_IR, mk(6'd0, 5'd0, 5'd0, 16'h8001));

    // Simultaneous load and write: write lands in old rd (3), not new rd (4).
    applyStimulus(0, 1, mk(6'd0, 5'd0, 5'd3, 16'h0), 0, 0, 32'h0, 32'h0, 0, 2'b00);
    applyStimulus(0, 1, mk(6'd0, 5'd0, 5'd4, 16'h0), 1, 0, 32'h00000055, 32'h0, 0, 2'b00);
    expectOutput("simul_ir_old", SEL_IR, mk(6'd0, 5'd0, 5'd3, 16'h0));
    applyStimulus(0, 1, mk(6'd0, 5'd3, 5'd4, 16'h0), 0, 0, 32'h0, 32'h0, 1, 2'b00);
    expectOutput("simul_ir_new", SEL_IR, mk(6'd0, 5'd0, 5'd4, 16'h0));
    applyStimulus(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 1, 2'b00);
    expectOutput("simul_r3", SEL_RFA, 32'h00000055);
    expectOutput("simul_r4", SEL_RFB, 32'h0);

    // Reset mid-instruction with a write pending clears everything.
    applyStimulus(0, 1, mk(6'd0, 5'd0, 5'd5, 16'h0), 0, 0, 32'h0, 32'h0, 0, 2'b00);
    applyStimulus(1, 0, 32'h0, 1, 0, 32'h00000111, 32'h0, 0, 2'b00);
    applyStimulus(0, 1, mk(6'd0, 5'd5, 5'd9, 16'h0), 0, 0, 32'h0, 32'h0, 1, 2'b00);
    expectOutput("midreset_ir", SEL_IR, 32'h0);
    applyStimulus(0, 0, 32'h0, 0, 0, 32'hxxxxxxxx, 32'hxxxxxxxx, 1, 2'b00);
    expectOutput("midreset_r5", SEL_RFA, 32'h0);
    expectOutput("midreset_r9", SEL_RFB, 32'h0);

    // Undriven write data with writes disabled must not disturb state.
    applyStimulus(0, 0, 32'h0, 0, 1, 32'hxxxxxxxx, 32'hxxxxxxxx, 1, 2'b00);
    expectOutput("xdata_r5", SEL_RFA, 32'h0);
    expectOutput("xdata_r9", SEL_RFB, 32'h0);

    // Drain the scoreboard with a bounded wait.
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
      @(posedge clk);
    end
    @(posedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decstage.md
# decstage

Instruction-decode stage of the MIPS-style datapath, directly downstream of the instruction-fetch stage. It consumes the fetch stage's `Instr`, holds it in an instruction register (IR), and extracts the register and immediate fields. It contains the 32x32 register file and the immediate extender. It supplies `RF_A`, `RF_B` and `Immed` to the execute stage, and `Immed` to the fetch stage's `PC_Immed`. Write-back data is returned from the ALU and memory stages.

## Interface
- `IR_RESET`, default 32'h00000000: IR value after reset.
- `Clk` in 1: rising-edge clock.
- `Reset` in 1: synchronous, active-high.
- `Instr` in 32: instruction word from the fetch stage.
- `IR_LdEn` in 1: load `Instr` into IR at the clock edge.
- `RF_WrEn` in 1: register-file write enable.
- `RF_WrData_sel` in 1: write-data source; 0 = `ALU_out`, 1 = `MEM_out`.
- `ALU_out` in 32: ALU result for write-back.
- `MEM_out` in 32: memory load data for write-back.
- `RF_B_sel` in 1: port-B address source; 0 = rt `IR[15:11]`, 1 = rd `IR[20:16]`.
- `ImmExt` in 2: immediate mode.
- `IR` out 32: current instruction, for the control unit.
- `Immed` out 32: extended immediate.
- `RF_A` out 32: register read port A, addressed by rs `IR[25:21]`.
- `RF_B` out 32: register read port B.

## Operation
- Field map:
  - opcode = `IR[31:26]`
  - rs = `IR[25:21]`
  - rd = `IR[20:16]`
  - rt = `IR[15:11]`
  - imm = `IR[15:0]`
- IR update:
  - When `IR_LdEn`=1, IR <= `Instr` at the edge.
  - Otherwise IR holds its value.
- Register file:
  - 32 entries of 32 bits.
  - Write address is always rd = `IR[20:16]` of the current IR.
  - Write data is `MEM_out` if `RF_WrData_sel`=1, else `ALU_out`.
  - Writes occur at the edge when `RF_WrEn`=1.
- R0:
  - Reads of address 0 always return 0.
  - Writes to address 0 are discarded; no storage change.
- Reads:
  - Combinational from the current IR fields and the array.
- Bypass (write-through):
  - Applies when `RF_WrEn`=1, the write address is nonzero, and it equals a port's read address.
  - In that case the port outputs the selected write data in the same cycle, before the edge.
  - Bypass applies independently to both ports.
- Immediate extension:
  - 00: zero-extend `imm`.
  - 01: sign-extend `imm`.
  - 10: {`imm`, 16'h0000} (load-upper).
  - 11: reserved; behaves as 01.
  - No shift is applied here; the fetch stage applies the <<2 for branch offsets.
- Simultaneous `IR_LdEn` and `RF_WrEn` at the same edge: the write uses the rd field of the IR value before the edge (old instruction); the new instruction is visible only after the edge.

## Timing
- Reset (synchronous, highest priority over `IR_LdEn` and `RF_WrEn`):
  - IR <= `IR_RESET`.
  - All 32 registers <= 0.
  - Any write requested in the reset cycle is lost.
- After reset, with the default `IR_RESET`: `IR`=0, `RF_A`=0, `RF_B`=0, `Immed`=0.
- IR latency: `Instr` sampled at edge N appears on `IR` after edge N. Fields, `Immed`, `RF_A` and `RF_B` follow combinationally within the same cycle.
- Write latency: data written at edge N is readable without bypass from the cycle after edge N. Via bypass it is visible in the cycle before edge N.
- Reset asserted mid-instruction (IR loaded, write pending): the reset cycle clears everything; no partial write survives.
- `RF_WrEn` held for multiple cycles with IR unchanged: the same register is rewritten each edge with the current data. This is legal.
- X/undriven `ALU_out` or `MEM_out` while `RF_WrEn`=0 must not affect state.

## Test plan
- Reset then idle:
  - Assert `Reset` for 1 edge with `RF_WrEn`=1 and `IR_LdEn`=1 -> after the edge, `IR`=0, `RF_A`=`RF_B`=0, `Immed`=0.
  - Read all 32 registers (stepping IR rs/rd fields) -> all read 0.
- Write/read:
  - Load IR with rd=5; `ALU_out`=32'hDEADBEEF; `RF_WrEn`=1; `RF_WrData_sel`=0 for 1 edge.
  - Load IR with rs=5 -> `RF_A`=32'hDEADBEEF.
  - Repeat with `RF_WrData_sel`=1 and `MEM_out`=32'h12345678 into rd=9 -> reading with `RF_B_sel`=1, rd=9 gives 32'h12345678.
- R0:
  - Write 32'hFFFFFFFF with rd=0 -> rs=0 reads 0.
  - Bypass does not fire: `RF_A`=0 during the write cycle.
- Bypass:
  - IR with rs=7 and rd=7; `RF_WrEn`=1; `ALU_out`=32'hA5A5A5A5 -> `RF_A`=32'hA5A5A5A5 before the edge, and stays so after the edge with `RF_WrEn`=0.
- Immediate modes with imm=16'h8001:
  - `ImmExt`=00 -> 32'h00008001.
  - `ImmExt`=01 -> 32'hFFFF8001.
  - `ImmExt`=10 -> 32'h80010000.
  - `ImmExt`=11 -> 32'hFFFF8001.
- IR hold / simultaneous load:
  - `IR_LdEn`=0 while `Instr` changes -> `IR` unchanged.
  - IR rd=3, `Instr` with rd=4, `IR_LdEn`=1 and `RF_WrEn`=1 with `ALU_out`=32'h55 at the same edge -> r3=32'h55, r4 unchanged (0).
